// File: rtl/hazard_sequencer_if.sv
// Decode/EX-side hazard inputs and IF/ID control outputs of the hazard sequencer.
// master = pipeline/divider side, slave = hazard_sequencer.
interface hazard_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_EX;
    logic             memread_EX;
    logic             muldiv_ID;
    logic             mispredict_EX;
    logic             div_done;
    logic             pc_hold;
    logic             stall;
    logic             flush;
    logic             div_start;
    logic             div_abort;
    logic             div_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_ID, rs2_ID, rd_EX, memread_EX, muldiv_ID, mispredict_EX, div_done,
        input  pc_hold, stall, flush, div_start, div_abort, div_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_ID, rs2_ID, rd_EX, memread_EX, muldiv_ID, mispredict_EX, div_done,
        output pc_hold, stall, flush, div_start, div_abort, div_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use interlock, mispredict flush and divider start/wait/abort/timeout sequencing.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int DIV_MAX_CYCLES = 34,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_W          = 32
) (
    input logic               clk,
    input logic               rst,
    hazard_sequencer_if.slave bus
);
    localparam int DCNT_W = $clog2(DIV_MAX_CYCLES) + 1;
    localparam int FCNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST    = DCNT_W'(DIV_MAX_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_RELOAD  = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE     = FCNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
    logic              timeout_reg, timeout_next;

    logic loaduse;
    logic pc_hold_c, stall_c, flush_c, start_c, abort_c, timeout_now;

    assign loaduse = bus.memread_EX && (bus.rd_EX != 5'd0) &&
                     ((bus.rd_EX == bus.rs1_ID) || (bus.rd_EX == bus.rs2_ID));

    always_comb begin
        state_next  = state_reg;
        dcnt_next   = dcnt_reg;
        fcnt_next   = fcnt_reg;
        pc_hold_c   = 1'b0;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        start_c     = 1'b0;
        abort_c     = 1'b0;
        timeout_now = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.mispredict_EX) begin
                    flush_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = FLUSH;
                        fcnt_next  = FCNT_RELOAD;
                    end
                end else if (loaduse) begin
                    // The pipeline advances past the hazard, so one cycle is one bubble.
                    stall_c   = 1'b1;
                    pc_hold_c = 1'b1;
                end else if (bus.muldiv_ID) begin
                    start_c    = 1'b1;
                    stall_c    = 1'b1;
                    pc_hold_c  = 1'b1;
                    state_next = DIV_WAIT;
                    dcnt_next  = '0;
                end
            end
            DIV_WAIT: begin
                dcnt_next = dcnt_reg + DCNT_W'(1);
                if (bus.mispredict_EX) begin
                    abort_c    = 1'b1;
                    flush_c    = 1'b1;
                    state_next = RUN;
                end else if (bus.div_done) begin
                    // A result arriving on the last allowed cycle still counts as success.
                    state_next = RUN;
                end else if (dcnt_reg == DCNT_LAST) begin
                    abort_c     = 1'b1;
                    timeout_now = 1'b1;
                    state_next  = RUN;
                end else begin
                    stall_c   = 1'b1;
                    pc_hold_c = 1'b1;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (bus.mispredict_EX) begin
                    fcnt_next = FCNT_RELOAD;
                end else if (fcnt_reg == FCNT_ONE) begin
                    state_next = RUN;
                end else begin
                    fcnt_next = fcnt_reg - FCNT_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
        timeout_next = timeout_reg | timeout_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RUN;
            dcnt_reg    <= '0;
            fcnt_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dcnt_reg    <= dcnt_next;
            fcnt_reg    <= fcnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.pc_hold     = !rst && pc_hold_c;
    assign bus.stall       = !rst && stall_c;
    assign bus.flush       = !rst && flush_c;
    assign bus.div_start   = !rst && start_c;
    assign bus.div_abort   = !rst && abort_c;
    assign bus.div_timeout = !rst && timeout_next;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_c && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            // Every state accepts a mispredict, so each one is a flush event.
            if (bus.mispredict_EX && !(&flush_cnt_reg)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = rst ? '0 : stall_cnt_reg;
    assign bus.flush_cnt = rst ? '0 : flush_cnt_reg;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: a vector table plus hand-written multi-cycle sequences, compared
// through a scoreboard queue. dut_a uses FLUSH_CYCLES=1, dut_b uses FLUSH_CYCLES=2.
module tb_hazard_sequencer;
    localparam int CNT_W = 32;

    // Expected output vector: {pc_hold, stall, flush, div_start, div_abort, div_timeout}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_LU    = 6'b110000;
    localparam logic [5:0] E_START = 6'b110100;
    localparam logic [5:0] E_FL    = 6'b001000;
    localparam logic [5:0] E_ABFL  = 6'b001010;
    localparam logic [5:0] E_TO    = 6'b000011;
    localparam logic [5:0] T_BIT   = 6'b000001;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] EXP_STALL_CNT = 3;
    localparam logic [CNT_W-1:0] EXP_FLUSH_CNT = 1;
`else
    localparam logic [CNT_W-1:0] EXP_STALL_CNT = 0;
    localparam logic [CNT_W-1:0] EXP_FLUSH_CNT = 0;
`endif

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       memread;
        logic       muldiv;
        logic       mispredict;
        logic       div_done;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        bit         sel;
        logic [5:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       memread = 1'b0, muldiv = 1'b0, mispredict = 1'b0, div_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int tx     = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    hazard_sequencer_if #(.CNT_W(CNT_W)) bus_a ();
    hazard_sequencer_if #(.CNT_W(CNT_W)) bus_b ();

    assign bus_a.rs1_ID = rs1;         assign bus_b.rs1_ID = rs1;
    assign bus_a.rs2_ID = rs2;         assign bus_b.rs2_ID = rs2;
    assign bus_a.rd_EX = rd;           assign bus_b.rd_EX = rd;
    assign bus_a.memread_EX = memread; assign bus_b.memread_EX = memread;
    assign bus_a.muldiv_ID = muldiv;   assign bus_b.muldiv_ID = muldiv;
    assign bus_a.mispredict_EX = mispredict; assign bus_b.mispredict_EX = mispredict;
    assign bus_a.div_done = div_done;  assign bus_b.div_done = div_done;

    hazard_sequencer #(.DIV_MAX_CYCLES(34), .FLUSH_CYCLES(1), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    hazard_sequencer #(.DIV_MAX_CYCLES(34), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    function automatic vec_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] d, input logic mr, input logic md,
                                input logic mp, input logic dd, input logic [5:0] e);
        vec_t v;
        v.rst = r; v.rs1 = a; v.rs2 = b; v.rd = d;
        v.memread = mr; v.muldiv = md; v.mispredict = mp; v.div_done = dd; v.exp = e;
        return v;
    endfunction

    // Drive one cycle, push the expectation, compare at the falling edge.
    task automatic step(input vec_t v, input bit sel, input string name);
        sb_t s;
        logic [5:0] act;
        rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        memread = v.memread; muldiv = v.muldiv; mispredict = v.mispredict;
        div_done = v.div_done;
        s.name = name; s.sel = sel; s.exp = v.exp;
        sb_q.push_back(s);
        @(negedge clk);
        s = sb_q.pop_front();
        if (s.sel)
            act = {bus_b.pc_hold, bus_b.stall, bus_b.flush,
                   bus_b.div_start, bus_b.div_abort, bus_b.div_timeout};
        else
            act = {bus_a.pc_hold, bus_a.stall, bus_a.flush,
                   bus_a.div_start, bus_a.div_abort, bus_a.div_timeout};
        checks++;
        tx++;
        if (act !== s.exp) begin
            errors++;
            $display("FAIL tx %0d %s dut_%s: got hold/stall/flush/start/abort/to=%b want %b",
                     tx, s.name, s.sel ? "b" : "a", act, s.exp);
        end else begin
            $display("tx %0d %s dut_%s: outputs=%b ok", tx, s.name, s.sel ? "b" : "a", act);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel, input string name, input logic [5:0] e);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, e), sel, name);
    endtask

    task automatic do_reset();
        step(mk(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, E_NONE), 1'b0, "reset_a");
        step(mk(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, E_NONE), 1'b1, "reset_b");
    endtask

    task automatic chk_cnt(input string name, input logic [CNT_W-1:0] act,
                           input logic [CNT_W-1:0] exp);
        checks++;
        tx++;
        if (act !== exp) begin
            errors++;
            $display("FAIL tx %0d %s: got %0d want %0d", tx, name, act, exp);
        end else begin
            $display("tx %0d %s: %0d ok", tx, name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        tbl[0] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_NONE);  // idle
        tbl[1] = mk(0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0, E_LU);    // rs1 load-use
        tbl[2] = mk(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_NONE);  // rd=x0 never hazards
        tbl[3] = mk(0, 5'd1, 5'd9, 5'd9, 1, 0, 0, 0, E_LU);    // rs2 load-use
        tbl[4] = mk(0, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0, E_NONE);  // not a load
        tbl[5] = mk(0, 5'd5, 5'd0, 5'd7, 1, 0, 0, 0, E_NONE);  // no register match
        tbl[6] = mk(0, 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, E_FL);    // mispredict beats load-use
        tbl[7] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_NONE);  // stray div_done ignored
        tbl[8] = mk(0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, E_LU);    // load-use beats muldiv

        @(posedge clk);
        #1;
        do_reset();
        chk_cnt("reset_stall_cnt", bus_a.stall_cnt, '0);
        chk_cnt("reset_flush_cnt", bus_a.flush_cnt, '0);

        for (int i = 0; i < 9; i++) step(tbl[i], 1'b0, $sformatf("table%0d", i));

        // Divider completes 10 cycles after start.
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_START), 1'b0, "div_start");
        for (int i = 0; i < 9; i++) step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_LU), 1'b0, "div_wait");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, E_NONE), 1'b0, "div_done");
        idle(1'b0, "after_done", E_NONE);

        // Mispredict during a divide aborts it.
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_START), 1'b0, "div_start2");
        idle(1'b0, "div_wait2", E_LU);
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_ABFL), 1'b0, "div_mispredict");
        idle(1'b0, "after_abort", E_NONE);

        // div_done on the final allowed cycle wins over timeout.
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_START), 1'b0, "div_start3");
        for (int i = 0; i < 33; i++) idle(1'b0, "div_wait3", E_LU);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, E_NONE), 1'b0, "done_at_limit");
        idle(1'b0, "no_timeout", E_NONE);

        // Timeout: abort on the 34th wait cycle, sticky flag afterwards.
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_START), 1'b0, "div_start4");
        for (int i = 0; i < 33; i++) idle(1'b0, "div_wait4", E_LU);
        idle(1'b0, "timeout", E_TO);
        idle(1'b0, "timeout_sticky", T_BIT);
        step(mk(0, 5'd3, 5'd0, 5'd3, 1, 0, 0, 0, E_LU | T_BIT), 1'b0, "lu_sticky");
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_START | T_BIT), 1'b0, "div_start5");
        idle(1'b0, "div_wait5", E_LU | T_BIT);

        // Reset mid-divide, then a fresh start.
        step(mk(1, 5'd4, 5'd0, 5'd4, 1, 1, 0, 0, E_NONE), 1'b0, "rst_in_wait");
        idle(1'b0, "after_rst", E_NONE);
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, E_START), 1'b0, "restart");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, E_NONE), 1'b0, "restart_done");

        // Two-cycle flush on dut_b; load-use is squashed by the mispredict.
        do_reset();
        step(mk(0, 5'd6, 5'd0, 5'd6, 1, 0, 1, 0, E_FL), 1'b1, "flush2_c1");
        step(mk(0, 5'd6, 5'd0, 5'd6, 1, 0, 0, 0, E_FL), 1'b1, "flush2_c2");
        idle(1'b1, "flush2_end", E_NONE);
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_FL), 1'b1, "reload_c1");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_FL), 1'b1, "reload_c2");
        idle(1'b1, "reload_c3", E_FL);
        idle(1'b1, "reload_end", E_NONE);

        // Performance counters: 3 load-use stalls and 1 mispredict.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(mk(0, 5'd8, 5'd0, 5'd8, 1, 0, 0, 0, E_LU), 1'b0, "cnt_lu");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, E_FL), 1'b0, "cnt_mp");
        idle(1'b0, "cnt_idle", E_NONE);
        chk_cnt("stall_cnt", bus_a.stall_cnt, EXP_STALL_CNT);
        chk_cnt("flush_cnt", bus_a.flush_cnt, EXP_FLUSH_CNT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
